// File: rtl/dm_responder.sv
// dm_responder: handshaked load/store data memory with programmable wait states; define DM_ALIGN_CHECK_EN to reject misaligned half/word accesses
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_byte,
  input  logic        req_half,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic we_q, we_d, byte_q, byte_d, half_q, half_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic rv_q, rv_d, er_q, er_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] ea, old_w, new_w, mask, ld;
  logic [15:0] sel;
  logic [4:0] sh;
  logic [AW-1:0] idx;
  logic oor, err, do_write;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = rv_q;
  assign resp_rdata = rd_q;
  assign resp_err   = er_q;
  // Decode the latched request: effective address, range/alignment error, store merge and load extract
  always_comb begin
    ea = byte_q ? addr_q : half_q ? {addr_q[31:1], 1'b0} : {addr_q[31:2], 2'b00};
    oor = ea[31:2] >= 30'(DEPTH_WORDS);
`ifdef DM_ALIGN_CHECK_EN
    err = oor | (~byte_q & half_q & addr_q[0]) | (~byte_q & ~half_q & |addr_q[1:0]);
`else
    err = oor;
`endif
    idx = ea[AW+1:2];
    old_w = oor ? '0 : mem_q[idx];
    sh = {ea[1:0], 3'b000};
    mask = byte_q ? 32'hFF << sh : half_q ? 32'hFFFF << sh : '1;
    new_w = (old_w & ~mask) | ((wdata_q << sh) & mask);
    sel = 16'(old_w >> sh);
    ld = byte_q ? {{24{sel[7]}}, sel[7:0]} : half_q ? {{16{sel[15]}}, sel} : old_w;
  end
  // Request/response FSM: latch in IDLE, count down in WAIT, hold response in RESP until taken
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    byte_d = byte_q;
    half_d = half_q;
    rv_d = rv_q;
    rd_d = rd_q;
    er_d = er_q;
    do_write = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        addr_d = req_addr;
        wdata_d = req_wdata;
        byte_d = req_byte;
        half_d = req_half;
        cnt_d = 8'(WAIT_CYCLES);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 8'd0) begin
        state_d = RESP;
        rv_d = 1'b1;
        er_d = err;
        rd_d = (err | we_q) ? '0 : ld;
        do_write = we_q & ~err;
      end else cnt_d = cnt_q - 8'd1;
      RESP: if (resp_ready) begin
        state_d = IDLE;
        rv_d = 1'b0;
        rd_d = '0;
        er_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Control and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      byte_q <= 1'b0;
      half_q <= 1'b0;
      rv_q <= 1'b0;
      rd_q <= '0;
      er_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      byte_q <= byte_d;
      half_q <= half_d;
      rv_q <= rv_d;
      rd_q <= rd_d;
      er_q <= er_d;
    end
  end
  // Storage: cleared on reset, a store commits on the edge that enters RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    else if (do_write) mem_q[idx] <= new_w;
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized bench for dm_responder (WAIT_CYCLES=2 and 0) against a byte-array memory model
module tb_dm_responder;
  logic clk = 0, reset = 0;
  logic req_valid [2], req_ready [2], req_we [2], req_byte [2], req_half [2];
  logic resp_valid [2], resp_ready [2], resp_err [2];
  logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_byte(req_byte[0]), .req_half(req_half[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_byte(req_byte[1]), .req_half(req_half[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  function automatic int wc(int d);
    return d == 0 ? 2 : 0;
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL dut%0d %s: actual=%h required=%h at %0t", d, name, act, exp, $time);
    end
  endtask

  // Model state: byte-addressed memory, one outstanding transaction per DUT
  bit [7:0] mm [2][12288];
  bit busy [2], exp_err [2], pw_en [2];
  int age [2], pw_s [2];
  logic [31:0] exp_rd [2], pw_a [2], pw_d [2];

  function automatic void accept(int d);
    logic [31:0] a, v;
    int s;
    bit e;
    a = req_addr[d];
    s = req_byte[d] ? 1 : req_half[d] ? 2 : 4;
`ifdef DM_ALIGN_CHECK_EN
    e = (a % s) != 0;
`else
    e = 0;
    a = a & ~32'(s - 1);
`endif
    e = e | ((a >> 2) >= 3072);
    exp_err[d] = e;
    exp_rd[d] = '0;
    pw_en[d] = 0;
    if (!e && req_we[d]) begin
      pw_en[d] = 1;
      pw_a[d] = a;
      pw_d[d] = req_wdata[d];
      pw_s[d] = s;
    end else if (!e) begin
      v = '0;
      for (int i = 0; i < s; i++) v = v | (32'(mm[d][a + i]) << (8 * i));
      if (s < 4 && v[8 * s - 1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
      exp_rd[d] = v;
    end
    busy[d] = 1;
    age[d] = 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        busy[d] = 0;
        pw_en[d] = 0;
        for (int i = 0; i < 12288; i++) mm[d][i] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          if (age[d] > wc(d) && resp_ready[d]) busy[d] = 0;
          else begin
            age[d]++;
            if (age[d] == wc(d) + 1 && pw_en[d]) begin
              for (int i = 0; i < pw_s[d]; i++) mm[d][pw_a[d] + i] = 8'(pw_d[d] >> (8 * i));
              pw_en[d] = 0;
            end
          end
        end else if (req_valid[d]) accept(d);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, req_ready[d], !busy[d]);
        chk("resp_valid", d, resp_valid[d], busy[d] && age[d] > wc(d));
        if (busy[d] && age[d] > wc(d)) begin
          chk("resp_rdata", d, resp_rdata[d], exp_rd[d]);
          chk("resp_err", d, resp_err[d], exp_err[d]);
        end
      end
    end
  end

  task automatic txn(int d, bit we, logic [31:0] addr, logic [31:0] wdata, bit b, bit h,
                     int delay, bit pin, logic [31:0] lit_rd, bit lit_err);
    int lat;
    req_valid[d] = 1;
    req_we[d] = we;
    req_addr[d] = addr;
    req_wdata[d] = wdata;
    req_byte[d] = b;
    req_half[d] = h;
    @(posedge clk);
    #1;
    req_valid[d] = 1'($urandom);
    req_we[d] = 1'($urandom);
    req_addr[d] = $urandom;
    req_wdata[d] = $urandom;
    req_byte[d] = 1'($urandom);
    req_half[d] = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!resp_valid[d] && lat < 300);
    chk("latency", d, lat, wc(d) + 1);
    if (pin) begin
      chk("pin_rdata", d, resp_rdata[d], lit_rd);
      chk("pin_err", d, resp_err[d], lit_err);
      chk("model_rdata", d, exp_rd[d], lit_rd);
    end
    repeat (delay) @(negedge clk);
    resp_ready[d] = 1;
    @(posedge clk);
    #1;
    resp_ready[d] = 0;
    req_valid[d] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int r;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = '0; req_wdata[d] = '0;
      req_byte[d] = 0; req_half[d] = 0; resp_ready[d] = 0;
    end
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, req_ready[d], 1);
      chk("rst_resp_valid", d, resp_valid[d], 0);
      chk("rst_resp_rdata", d, resp_rdata[d], 0);
      chk("rst_resp_err", d, resp_err[d], 0);
    end
    @(posedge clk);
    #1 reset = 1;
    txn(0, 1, 32'h10, 32'h12345678, 0, 0, 0, 1, 32'h0, 0);
    txn(0, 0, 32'h10, 32'h0, 0, 0, 0, 1, 32'h12345678, 0);
    txn(0, 1, 32'h11, 32'h000000AB, 1, 0, 1, 1, 32'h0, 0);
    txn(0, 0, 32'h10, 32'h0, 0, 0, 0, 1, 32'h1234AB78, 0);
    txn(0, 0, 32'h11, 32'h0, 1, 0, 0, 1, 32'hFFFFFFAB, 0);
    txn(0, 1, 32'h22, 32'h00008001, 0, 1, 0, 1, 32'h0, 0);
    txn(0, 0, 32'h22, 32'h0, 0, 1, 0, 1, 32'hFFFF8001, 0);
    txn(0, 0, 32'h20, 32'h0, 0, 0, 0, 1, 32'h80010000, 0);
    txn(0, 0, 32'h3000, 32'h0, 0, 0, 5, 1, 32'h0, 1);
    txn(1, 0, 32'h3000, 32'h0, 0, 0, 5, 1, 32'h0, 1);
    txn(0, 0, 32'h2FFC, 32'h0, 0, 0, 0, 1, 32'h0, 0);
    // store accepted, reset during WAIT, then the word must read back as zero
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h40; req_wdata[0] = 32'hDEADBEEF;
    req_byte[0] = 0; req_half[0] = 0;
    @(posedge clk);
    #1 req_valid[0] = 0;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("midrst_resp_valid", 0, resp_valid[0], 0);
    chk("midrst_req_ready", 0, req_ready[0], 1);
    @(posedge clk);
    #1 reset = 1;
    txn(0, 0, 32'h40, 32'h0, 0, 0, 0, 1, 32'h0, 0);
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 32'h10, 32'h9ABC5678, 0, 0, 0, 1, 32'h0, 0);
`ifdef DM_ALIGN_CHECK_EN
      txn(d, 0, 32'h13, 32'h0, 0, 1, 0, 1, 32'h0, 1);
`else
      txn(d, 0, 32'h13, 32'h0, 0, 1, 0, 1, 32'hFFFF9ABC, 0);
`endif
    end
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = r < 8 ? 32'($urandom_range(0, 255)) : r == 8 ? 32'h2FF0 + 32'($urandom_range(0, 31)) : $urandom;
      txn(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, $urandom_range(0, 3) == 0,
          1'($urandom), int'($urandom_range(0, 3)), 0, 32'h0, 0);
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
